// File: rtl/accum_pkg.sv
// Shared types for the arithmetic-series accumulator.
// Holds the controller state encoding and default width.
package accum_pkg;

  localparam int ACCUM_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    ADD,
    DONE
  } accum_state_t;

endpackage

// File: rtl/accum_series_proc_if.sv
// Start/busy/done handshake and operand/result bundle
// for the series accumulator.
interface accum_series_proc_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] n_start;
  logic [WIDTH-1:0] n_end;
  logic [WIDTH-1:0] n_step;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] o_sum;
  logic             ovf;

  modport master (
    output start,
    output n_start,
    output n_end,
    output n_step,
    input  busy,
    input  done,
    input  o_sum,
    input  ovf
  );

  modport slave (
    input  start,
    input  n_start,
    input  n_end,
    input  n_step,
    output busy,
    output done,
    output o_sum,
    output ovf
  );

endinterface

// File: rtl/accum_datapath.sv
// Series accumulator datapath: operand latches, running n/sum
// with carry tracking, loop compare and result register.
module accum_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             init,
  input  logic             add,
  input  logic             commit,
  input  logic [WIDTH-1:0] n_start_i,
  input  logic [WIDTH-1:0] n_end_i,
  input  logic [WIDTH-1:0] n_step_i,
  output logic             cont_o,
  output logic [WIDTH-1:0] o_sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_int_q, ovf_int_d;
  logic             nwrap_q, nwrap_d;
  logic [WIDTH-1:0] o_sum_q, o_sum_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] n_ext;

  assign sum_ext = {1'b0, sum_q} + {1'b0, n_q};
  assign n_ext   = {1'b0, n_q} + {1'b0, step_q};

  // nwrap ends the loop so n_end at the max value cannot spin forever
  assign cont_o = (n_q <= end_q) && !nwrap_q;
  assign o_sum  = o_sum_q;
  assign ovf    = ovf_q;

  always_comb begin
    start_d   = start_q;
    end_d     = end_q;
    step_d    = step_q;
    n_d       = n_q;
    sum_d     = sum_q;
    ovf_int_d = ovf_int_q;
    nwrap_d   = nwrap_q;
    o_sum_d   = o_sum_q;
    ovf_d     = ovf_q;
    if (load) begin
      start_d = n_start_i;
      end_d   = n_end_i;
      step_d  = (n_step_i == '0) ? ONE : n_step_i;
    end
    if (init) begin
      n_d       = start_q;
      sum_d     = '0;
      ovf_int_d = 1'b0;
      nwrap_d   = 1'b0;
    end
    if (add) begin
      sum_d     = sum_ext[WIDTH-1:0];
      ovf_int_d = ovf_int_q | sum_ext[WIDTH];
      n_d       = n_ext[WIDTH-1:0];
      nwrap_d   = nwrap_q | n_ext[WIDTH];
    end
    if (commit) begin
      o_sum_d = sum_q;
      ovf_d   = ovf_int_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= '0;
      end_q     <= '0;
      step_q    <= '0;
      n_q       <= '0;
      sum_q     <= '0;
      ovf_int_q <= 1'b0;
      nwrap_q   <= 1'b0;
      o_sum_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      start_q   <= start_d;
      end_q     <= end_d;
      step_q    <= step_d;
      n_q       <= n_d;
      sum_q     <= sum_d;
      ovf_int_q <= ovf_int_d;
      nwrap_q   <= nwrap_d;
      o_sum_q   <= o_sum_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: rtl/accum_series_proc.sv
// Arithmetic-series accumulator: controller FSM driving one
// datapath; result and overflow held until the next run.
module accum_series_proc
  import accum_pkg::*;
#(
  parameter int WIDTH = ACCUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  accum_series_proc_if.slave   bus
);

  accum_state_t state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load, init, add, commit, cont;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    init    = 1'b0;
    add     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        init    = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        // result is committed on entry so it is valid with done
        if (cont) begin
          state_d = ADD;
        end else begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      ADD: begin
        add     = 1'b1;
        state_d = CHECK;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  accum_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .init      (init),
    .add       (add),
    .commit    (commit),
    .n_start_i (bus.n_start),
    .n_end_i   (bus.n_end),
    .n_step_i  (bus.n_step),
    .cont_o    (cont),
    .o_sum     (bus.o_sum),
    .ovf       (bus.ovf)
  );

endmodule

// File: tb/tb_accum_series_proc.sv
// Directed bench for accum_series_proc: vector table of runs
// plus held-start, mid-run start and reset-abort sequences.
module tb_accum_series_proc;

  logic clk;
  logic rst;

  accum_series_proc_if #(.WIDTH(8)) bus ();

  accum_series_proc #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    logic [7:0] st;
    bit         mid;
    int         exp_sum;
    int         exp_ovf;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run(
    input  logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
    input  bit mid,
    output int lat, output int busy_n, output int held_ok,
    output int sum, output int ov, output int busy0
  );
    logic [7:0] prev;
    logic       prev_ovf;
    prev     = bus.o_sum;
    prev_ovf = bus.ovf;
    lat      = -1;
    busy_n   = 0;
    held_ok  = 1;
    sum      = -1;
    ov       = -1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_start = s;
    bus.n_end   = e;
    bus.n_step  = st;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy0 = int'(bus.busy);
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = k;
        sum = int'(bus.o_sum);
        ov  = int'(bus.ovf);
        break;
      end
      if (bus.o_sum !== prev || bus.ovf !== prev_ovf) held_ok = 0;
      if (mid && k == 4) begin
        bus.start   = 1'b1;
        bus.n_start = 8'd20;
        bus.n_end   = 8'd5;
        bus.n_step  = 8'd7;
      end
      if (mid && k == 5) bus.start = 1'b0;
    end
  endtask

  initial begin
    int lat, busy_n, held_ok, sum, ov, busy0;
    int d1, d2, dcnt;

    vecs[0] = '{8'd1,   8'd10,  8'd1,  1'b0, 55,  0, 22};
    vecs[1] = '{8'd1,   8'd10,  8'd3,  1'b0, 22,  0, 10};
    vecs[2] = '{8'd1,   8'd10,  8'd0,  1'b0, 55,  0, 22};
    vecs[3] = '{8'd0,   8'd255, 8'd1,  1'b0, 128, 1, 514};
    vecs[4] = '{8'd20,  8'd5,   8'd1,  1'b0, 0,   0, 2};
    vecs[5] = '{8'd1,   8'd10,  8'd1,  1'b1, 55,  0, 22};
    vecs[6] = '{8'd200, 8'd255, 8'd50, 1'b0, 194, 1, 6};
    vecs[7] = '{8'd5,   8'd5,   8'd1,  1'b0, 5,   0, 4};
    vecs[8] = '{8'd250, 8'd255, 8'd2,  1'b0, 244, 1, 8};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.n_start = '0;
    bus.n_end   = '0;
    bus.n_step  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_sum", int'(bus.o_sum), 0);
    chk("reset_ovf", int'(bus.ovf), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].mid,
          lat, busy_n, held_ok, sum, ov, busy0);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_ovf", i), ov, vecs[i].exp_ovf);
      chk($sformatf("v%0d_busy_first", i), busy0, 1);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].exp_lat);
      chk($sformatf("v%0d_held", i), held_ok, 1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), int'(bus.done), 0);
      chk($sformatf("v%0d_busy_end", i), int'(bus.busy), 0);
      chk($sformatf("v%0d_sum_kept", i), int'(bus.o_sum), vecs[i].exp_sum);
    end

    // start held high: second run accepted on the IDLE cycle after DONE
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_start = 8'd1;
    bus.n_end   = 8'd10;
    bus.n_step  = 8'd3;
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (d1 < 0) d1 = k;
        else begin
          d2 = k;
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("held_start_done1", d1, 10);
    chk("held_start_done2", d2, 22);
    chk("held_start_sum", int'(bus.o_sum), 22);
    repeat (3) @(posedge clk);
    #1;
    chk("held_start_idle", int'(bus.busy), 0);

    // reset while in ADD aborts the run and clears the result
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_start = 8'd1;
    bus.n_end   = 8'd10;
    bus.n_step  = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_sum", int'(bus.o_sum), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    run(8'd1, 8'd10, 8'd1, 1'b0, lat, busy_n, held_ok, sum, ov, busy0);
    chk("post_rst_latency", lat, 22);
    chk("post_rst_sum", sum, 55);
    chk("post_rst_ovf", ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
